// File: rtl/seq_mul41x15_if.sv
// seq_mul41x15_if
// Handshake bundle between the shift-add multiplier and its neighbours.
//   in_valid / in_ready       : operand handshake (upstream -> multiplier)
//   multiplicand [40:0]       : unsigned multiplicand
//   multiplier   [14:0]       : unsigned multiplier
//   out_valid / out_ready     : product handshake (multiplier -> downstream adder)
//   product      [55:0]       : unsigned product, feeds customAdder56_41.A
//   busy                      : multiplier is iterating or holding a result
// Modport slave is the multiplier's view; master is the view of the
// surrounding logic that supplies operands and consumes the product.
interface seq_mul41x15_if;
    logic        in_valid;
    logic        in_ready;
    logic [40:0] multiplicand;
    logic [14:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [55:0] product;
    logic        busy;

    modport slave (
        input  in_valid,
        input  multiplicand,
        input  multiplier,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy
    );

    modport master (
        output in_valid,
        output multiplicand,
        output multiplier,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy
    );
endinterface

// File: rtl/seq_mul41x15.sv
// seq_mul41x15
// Iterative shift-add multiplier: 41-bit x 15-bit unsigned -> 56-bit product,
// one multiplier bit per clock, fixed 15 iterations (no early exit).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, overrides every other event
//   bus  : seq_mul41x15_if.slave (operand and product handshakes, busy)
// Accept at edge k -> out_valid after edge k+15; product held until the
// next accept. All outputs come straight from flops.
module seq_mul41x15 (
    input  logic                clk,
    input  logic                rst,
    seq_mul41x15_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_q,     state_d;
    logic [40:0] mcand_q,     mcand_d;
    logic [14:0] mplr_q,      mplr_d;
    logic [55:0] acc_q,       acc_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic        in_ready_q,  in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q,      busy_d;

    logic        accept_s;
    logic [55:0] addend_s;

    // in_ready_q mirrors "state is IDLE", so this is the accept condition
    assign accept_s = bus.in_valid && in_ready_q;

    // Partial product for the current bit: zero-extended mcand shifted by cnt
    always_comb begin
        if (mplr_q[0]) begin
            addend_s = {15'd0, mcand_q} << cnt_q;
        end else begin
            addend_s = 56'd0;
        end
    end

    // State register plus datapath and output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mcand_q     <= 41'd0;
            mplr_q      <= 15'd0;
            acc_q       <= 56'd0;
            cnt_q       <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // cnt==14 is the last (15th) bit; leave RUN on that edge
                if (cnt_q == 4'd14) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: load on accept, shift-add while running, else hold
    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    mcand_d = bus.multiplicand;
                    mplr_d  = bus.multiplier;
                    acc_d   = 56'd0;
                    cnt_d   = 4'd0;
                end else begin
                    mcand_d = mcand_q;
                end
            end
            ST_RUN: begin
                // Max product < 2^56, so the 56-bit add cannot carry out
                acc_d  = acc_q + addend_s;
                mplr_d = {1'b0, mplr_q[14:1]};
                cnt_d  = cnt_q + 4'd1;
            end
            ST_DONE: begin
                acc_d = acc_q;
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // Output decode from the next state so the flags land with the state change
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            ST_IDLE: begin
                in_ready_d = 1'b1;
            end
            ST_RUN: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: begin
                in_ready_d = 1'b1;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.product   = acc_q;

endmodule

// File: tb/tb_seq_mul41x15.sv
// Self-checking bench for seq_mul41x15: directed vectors plus a random
// stream. Expected products are queued when operands are accepted and a
// monitor compares them whenever a product handshake completes.
module tb_seq_mul41x15;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_mul41x15_if bus ();

    seq_mul41x15 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [55:0] exp_q[$];
    logic [55:0] mon_exp;
    logic        dir_ready  = 1'b0;
    logic        rand_ready = 1'b0;
    logic        rand_mode  = 1'b0;

    assign bus.out_ready = rand_mode ? rand_ready : dir_ready;

    // Random downstream stalls, only used in random mode
    always @(posedge clk) begin
        #1;
        rand_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every completed product handshake
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL product_unexpected got=0x%0h expected=none at %0t", bus.product, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("product", {8'd0, bus.product}, {8'd0, mon_exp});
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 64'(bus.in_ready), 64'd1);
    endtask

    // Present operands until accepted; optionally check the 15-edge latency
    task automatic issue(input logic [40:0] a, input logic [14:0] b, input bit lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got=in_ready0 expected=in_ready1 at %0t", $time);
        end else begin
            bus.in_valid     = 1'b1;
            bus.multiplicand = a;
            bus.multiplier   = b;
            exp_q.push_back({15'd0, a} * {41'd0, b});
            @(posedge clk); #1;
            bus.in_valid     = 1'b0;
            // Operands are ignored after accept; scramble them
            bus.multiplicand = 41'($urandom);
            bus.multiplier   = 15'($urandom);
            if (lat) begin
                chk("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
                for (int i = 1; i < 15; i++) begin
                    @(posedge clk); #1;
                    chk("out_valid_early", 64'(bus.out_valid), 64'd0);
                    chk("in_ready_run", 64'(bus.in_ready), 64'd0);
                    chk("busy_run", 64'(bus.busy), 64'd1);
                end
                @(posedge clk); #1;
                chk("out_valid_latency", 64'(bus.out_valid), 64'd1);
                chk("in_ready_done", 64'(bus.in_ready), 64'd0);
            end
        end
    endtask

    logic        ov_seen;
    logic [56:0] mac_sum;
    int          n_drain;

    initial begin
        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.multiplicand = 41'd0;
        bus.multiplier   = 15'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_product", {8'd0, bus.product}, 64'd0);
        rst       = 1'b0;
        dir_ready = 1'b1;

        // Basic: 3 x 5 = 0x0F
        issue(41'd3, 15'd5, 1'b1);
        chk("basic_product", {8'd0, bus.product}, 64'h0F);

        // Max operands: (2^41-1)(2^15-1) = 0xFFFDFFFFFF8001
        issue(41'h1FFFFFFFFFF, 15'h7FFF, 1'b1);
        chk("max_product", {8'd0, bus.product}, 64'h00FFFDFFFFFF8001);
        mac_sum = {1'b0, bus.product} + 57'h7FFF;
        chk("max_mac_sum", {7'd0, mac_sum}, 64'h00FFFE0000000000);

        // Zero multiplier still takes 15 cycles
        issue(41'd12345, 15'd0, 1'b1);
        chk("zero_product", {8'd0, bus.product}, 64'd0);

        // Backpressure: 0x155 x 0x2AA = 341 x 682 = 232562 = 0x38C72
        wait_idle();
        dir_ready = 1'b0;
        issue(41'h155, 15'h2AA, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_product", {8'd0, bus.product}, 64'h38C72);
            bus.in_valid     = (i % 2 == 0);
            bus.multiplicand = 41'($urandom);
            bus.multiplier   = 15'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        dir_ready    = 1'b1;
        @(posedge clk); #1;
        chk("release_out_valid", 64'(bus.out_valid), 64'd0);
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("release_product_held", {8'd0, bus.product}, 64'h38C72);

        // Reset during RUN discards the operation
        issue(41'h1234, 15'h7FF, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_product", {8'd0, bus.product}, 64'd0);
        ov_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) ov_seen = 1'b1;
        end
        chk("midrst_no_out_valid", 64'(ov_seen), 64'd0);
        issue(41'd7, 15'd9, 1'b1);
        chk("after_rst_product", {8'd0, bus.product}, 64'h3F);

        // Random stream with random downstream stalls
        wait_idle();
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            issue({9'($urandom), $urandom}, 15'($urandom), 1'b0);
        end
        n_drain = 0;
        while (exp_q.size() != 0 && n_drain < 400) begin
            @(posedge clk); #1;
            n_drain++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
